shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter: N, 8, data width; the shift datapath is N bits wide with a 3-bit per-pass amount.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 holds a shift request.
- req0_data  in  N  requester 0 operand.
- req0_amt  in  4  requester 0 right-shift amount, 0..15.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req1_valid  in  1  requester 1 holds a shift request.
- req1_data  in  N  requester 1 operand.
- req1_amt  in  4  requester 1 right-shift amount, 0..15.
- req1_ready  out  1  requester 1 request accepted this cycle.
- rsp_valid  out  1  result available.
- rsp_data  out  N  shifted result.
- rsp_id  out  1  requester that owns the result.
- rsp_ready  in  1  consumer takes the result.
- busy  out  1  state is not IDLE.
REQ-003 Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.

Function
REQ-004 The block SHALL share one N-bit, 0..7-position right-shift datapath between two requesters, one request in flight at a time.
REQ-005 FSM states: IDLE, PASS_LO, PASS_HI1, PASS_HI2, RESP.
REQ-006 Transitions:
- IDLE -> PASS_LO on accept.
- PASS_LO -> PASS_HI1 if amt[3]=1, else RESP.
- PASS_HI1 -> PASS_HI2.
- PASS_HI2 -> RESP.
- RESP -> IDLE when rsp_ready=1.
REQ-007 Accept: a request is accepted when reqX_valid=1 and reqX_ready=1. reqX_ready=1 only in IDLE and only for the granted requester. At most one ready is high per cycle.
REQ-008 Capture on accept: operand into work register W, plus amt and requester id.
REQ-009 Shift per state:
- PASS_LO: W <= W shifted right by amt[2:0].
- PASS_HI1, PASS_HI2: W <= W shifted right by 4 each.
- Net shift SHALL equal amt.
REQ-010 Latency, accept edge to rsp_valid high: 2 cycles for amt<8, 4 cycles for amt>=8.
REQ-011 In RESP: rsp_valid=1, with rsp_data=W and rsp_id=captured id. All three SHALL stay stable until rsp_ready=1.
REQ-012 Arbitration is round-robin with a one-bit pointer naming the last-served requester.
- Both valid: grant the requester not last served.
- One valid: grant it.
- The pointer updates only on accept.
REQ-013 Requests that arrive while busy SHALL wait, and are never dropped or accepted.
REQ-014 rsp_ready=1 outside RESP SHALL be ignored.
REQ-015 In RESP with rsp_ready=1, the FSM returns to IDLE. No new accept happens in that same cycle; the next accept is possible one cycle later.

Reset
REQ-016 On rst_n low, regardless of clock or state:
- State becomes IDLE.
- rsp_valid, rsp_data, rsp_id, busy, req0_ready and req1_ready all go to 0.
- W and amt are cleared.
- The pointer favours req0 as first grant.
REQ-017 Reset in the middle of an operation SHALL abandon the in-flight request with no response.

Configuration
REQ-018 Macro SHIFT_ARB_ROTATE_EN:
- Defined: every pass SHALL rotate right, with bits leaving bit 0 entering bit N-1. The net result is rotate right by amt mod N.
- Undefined: every pass is a logical right shift with zero fill, so amt>=N yields 0.

Verification
REQ-019 Directed scenarios:
- V1: req0 data 0x80, amt 2, macro off -> rsp_data 0x20, rsp_id 0, rsp_valid 2 cycles after accept.
- V2: req1 data 0xFF, amt 9, macro off -> rsp_data 0x00, rsp_id 1, rsp_valid 4 cycles after accept. Same case with macro on, data 0x81 -> rsp_data 0xC0.
- V3: both valid from reset with distinct data -> req0 served first, then req1, then req0 again; no starvation across 6 requests.
- V4: rsp_ready held low 5 cycles in RESP (data 0xF0, amt 3) -> rsp_data 0x1E stable throughout; both readies low; busy=1.
- V5: rst_n asserted during PASS_HI1 -> all outputs 0 immediately; no response after release; the next simultaneous request grants req0.
- V6: amt 0, data 0xA5 -> rsp_data 0xA5 after 2 cycles; back-to-back requests are accepted no sooner than 1 cycle after the rsp handshake.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two requesters share one N-bit right-shift datapath under round-robin arbitration.
// Build option SHIFT_ARB_ROTATE_EN: every pass rotates right instead of zero-filling.
module shift_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_data,
  input  logic [3:0]   req0_amt,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_data,
  input  logic [3:0]   req1_amt,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic [N-1:0] rsp_data,
  output logic         rsp_id,
  input  logic         rsp_ready,
  output logic         busy
);

  localparam int unsigned AMT_W   = 4;
  localparam int unsigned PASS_W  = 3;
  localparam int unsigned HI_STEP = 4;

  typedef enum logic [2:0] {
    IDLE,
    PASS_LO,
    PASS_HI1,
    PASS_HI2,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     w_q, w_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             id_q, id_d;
  logic             ptr_q, ptr_d;
  logic             idle_q, idle_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic             gnt0, gnt1;
  logic             acc0, acc1;

  // One pass of the shared datapath: shift (or rotate) right by s positions.
  function automatic logic [N-1:0] pass_f(input logic [N-1:0] v, input logic [PASS_W-1:0] s);
`ifdef SHIFT_ARB_ROTATE_EN
    pass_f = N'({v, v} >> s);
`else
    pass_f = v >> s;
`endif
  endfunction

  // ptr_q names the last-served requester; the other one wins a tie.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || ptr_q);
    gnt1 = req1_valid && (!req0_valid || !ptr_q);
  end

  // idle_q stays low through reset and the first cycle after, so ready never rises in reset.
  assign req0_ready = idle_q && gnt0;
  assign req1_ready = idle_q && gnt1;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    amt_d   = amt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (acc0) begin
          w_d     = req0_data;
          amt_d   = req0_amt;
          id_d    = 1'b0;
          ptr_d   = 1'b0;
          state_d = PASS_LO;
        end else if (acc1) begin
          w_d     = req1_data;
          amt_d   = req1_amt;
          id_d    = 1'b1;
          ptr_d   = 1'b1;
          state_d = PASS_LO;
        end
      end
      PASS_LO: begin
        w_d     = pass_f(w_q, amt_q[PASS_W-1:0]);
        state_d = amt_q[AMT_W-1] ? PASS_HI1 : RESP;
      end
      PASS_HI1: begin
        w_d     = pass_f(w_q, PASS_W'(HI_STEP));
        state_d = PASS_HI2;
      end
      PASS_HI2: begin
        w_d     = pass_f(w_q, PASS_W'(HI_STEP));
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    idle_d      = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      amt_q       <= '0;
      id_q        <= 1'b0;
      ptr_q       <= 1'b1;
      idle_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      amt_q       <= amt_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      idle_q      <= idle_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = w_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

`ifndef SYNTHESIS
  a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));
  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: random and directed requests against a spec-level model.
module tb_shift_arbiter;
  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [N-1:0] req0_data, req1_data;
  logic [3:0]   req0_amt, req1_amt;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_ready, busy;
  logic [N-1:0] rsp_data;

  shift_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [N-1:0] d; logic [3:0] a; } req_t;
  typedef struct { logic [N-1:0] data; logic id; int due; } exp_t;

  req_t q0[$], q1[$];
  exp_t sb[$];
  int   n_checks = 0, n_fails = 0;
  int   cycle = 0;
  int   rr_mode = 0;
  bit   gap_en = 1'b0;
  bit   m_busy = 1'b0, m_last = 1'b1;
  int   n_rsp0 = 0, n_rsp1 = 0;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Net effect of a request straight from its definition, independent of pass structure.
  function automatic logic [N-1:0] ref_result(input logic [N-1:0] d, input int unsigned amt);
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
`ifdef SHIFT_ARB_ROTATE_EN
      r[i] = d[(i + amt) % N];
`else
      if (i + amt < N) r[i] = d[i + amt];
`endif
    end
    return r;
  endfunction

  // Monitor and model: predicts grants, busy and response timing/content each cycle.
  always @(negedge clk) begin
    bit g0, g1, exp_v;
    exp_t e;
    if (!rst_n) begin
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_busy", busy, 0);
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      sb.delete();
      m_busy = 1'b0;
      m_last = 1'b1;
    end else begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin
          g0 = m_last;
          g1 = !m_last;
        end else begin
          g0 = req0_valid;
          g1 = req1_valid;
        end
      end
      check("req0_ready", req0_ready, g0);
      check("req1_ready", req1_ready, g1);
      check("busy", busy, m_busy);
      exp_v = (sb.size() != 0) && (cycle >= sb[0].due);
      check("rsp_valid", rsp_valid, exp_v);
      if (exp_v && rsp_valid) begin
        check("rsp_data", rsp_data, sb[0].data);
        check("rsp_id", rsp_id, sb[0].id);
        if (rsp_ready) begin
          if (sb[0].id) n_rsp1++; else n_rsp0++;
          void'(sb.pop_front());
          m_busy = 1'b0;
        end
      end
      if (g0) begin
        e.data = ref_result(req0_data, req0_amt);
        e.id   = 1'b0;
        e.due  = cycle + ((req0_amt >= 8) ? 4 : 2);
        sb.push_back(e);
        m_busy = 1'b1;
        m_last = 1'b0;
      end else if (g1) begin
        e.data = ref_result(req1_data, req1_amt);
        e.id   = 1'b1;
        e.due  = cycle + ((req1_amt >= 8) ? 4 : 2);
        sb.push_back(e);
        m_busy = 1'b1;
        m_last = 1'b1;
      end
    end
  end

  // Requester and consumer drivers: hold each request until accepted, then take the next.
  initial begin
    bit a0, a1;
    req_t r;
    forever begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #2;
      if (!rst_n) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end else begin
        if (a0) req0_valid = 1'b0;
        if (a1) req1_valid = 1'b0;
        if (!req0_valid && q0.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
          r = q0.pop_front();
          req0_data = r.d; req0_amt = r.a; req0_valid = 1'b1;
        end
        if (!req1_valid && q1.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
          r = q1.pop_front();
          req1_data = r.d; req1_amt = r.a; req1_valid = 1'b1;
        end
      end
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic drain(input int maxc);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || req0_valid || req1_valid || sb.size() != 0) && k < maxc) begin
      @(posedge clk);
      k++;
    end
    n_checks++;
    if (k >= maxc) begin
      n_fails++;
      $display("FAIL drain: traffic still pending after %0d cycles (sb=%0d)", maxc, sb.size());
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_rsp(input int maxc);
    int k = 0;
    while (!rsp_valid && k < maxc) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (!rsp_valid) begin
      n_fails++;
      $display("FAIL wait_rsp: rsp_valid got 0 expected 1 within %0d cycles", maxc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic push0(input logic [N-1:0] d, input logic [3:0] a);
    req_t r;
    r.d = d; r.a = a;
    q0.push_back(r);
  endtask

  task automatic push1(input logic [N-1:0] d, input logic [3:0] a);
    req_t r;
    r.d = d; r.a = a;
    q1.push_back(r);
  endtask

  initial begin
    int k;
    bit found;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; req0_amt = '0; req1_amt = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // V1, V2, V6: single requests and back-to-back zero shifts
    push0(8'h80, 4'd2);
    drain(50);
    push1(8'hFF, 4'd9);
    drain(50);
    push1(8'h81, 4'd9);
    drain(50);
    push0(8'hA5, 4'd0); push0(8'hA5, 4'd0); push0(8'h5A, 4'd0);
    drain(60);

    // V4: consumer stalls five cycles in RESP
    rr_mode = 2;
    push0(8'hF0, 4'd3);
    wait_rsp(20);
    repeat (5) begin
      @(negedge clk);
      check("v4_rsp_data", rsp_data, 8'h1E);
      check("v4_busy", busy, 1);
    end
    rr_mode = 0;
    drain(50);

    // V3: both requesters valid from reset, round-robin alternation
    do_reset();
    n_rsp0 = 0; n_rsp1 = 0;
    for (int i = 0; i < 3; i++) begin
      push0(N'(8'h11 * (i + 1)), 4'(i + 1));
      push1(N'(8'h90 + i), 4'(i + 8));
    end
    drain(200);
    check("v3_served0", n_rsp0, 3);
    check("v3_served1", n_rsp1, 3);

    // V5: reset while the request sits in its first high pass
    push0(8'h3C, 4'd12);
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      @(negedge clk);
      found = req0_valid && req0_ready;
      k++;
    end
    check("v5_accept_seen", found, 1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    check("v5_rsp_valid", rsp_valid, 0);
    check("v5_rsp_data", rsp_data, 0);
    check("v5_busy", busy, 0);
    check("v5_ready0", req0_ready, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    n_rsp0 = 0; n_rsp1 = 0;
    push0(8'h0F, 4'd1);
    push1(8'hE1, 4'd4);
    drain(60);
    check("v5_post_served0", n_rsp0, 1);
    check("v5_post_served1", n_rsp1, 1);

    // Random traffic with random gaps and consumer back-pressure
    rr_mode = 1;
    gap_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push0(N'($urandom), 4'($urandom_range(0, 15)));
      push1(N'($urandom), 4'($urandom_range(0, 15)));
    end
    drain(3000);
    rr_mode = 0;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
